// File: rtl/keypad_emulator_if.sv
// Keypad emulator bus: the scanner-facing row/col matrix lines plus the press
// request/status handshake.
//   master : scanner/controller side (drives col and press requests)
//   slave  : emulator side (drives row and status)
interface keypad_emulator_if;
    logic [3:0] col;          // column strobes, active low, col[0] = leftmost
    logic [3:0] row;          // row returns, active low, row[0] = top
    logic [3:0] key_code;     // key to press, sampled on accepted press_req
    logic [7:0] hold_ms;      // stable-closed time in ms, 0 behaves as 1
    logic       press_req;    // single-cycle press request
    logic       busy;         // press in progress
    logic       done;         // one-cycle pulse on return to idle
    logic       req_dropped;  // press_req seen while busy
    logic       contact;      // emulated switch closure

    modport master (
        output col, key_code, hold_ms, press_req,
        input  row, busy, done, req_dropped, contact
    );

    modport slave (
        input  col, key_code, hold_ms, press_req,
        output row, busy, done, req_dropped, contact
    );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: responder end of a keypad scan bus. A commanded
// press bounces on make, stays closed for hold_ms milliseconds, then bounces on
// break. While closed, the row of the pressed key follows its column strobe
// combinationally, like the passive switch matrix it replaces.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   kp  : keypad_emulator_if.slave (col/row matrix, press request and status)
module keypad_emulator #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned BOUNCE_CYCLES = 50_000,
    parameter int unsigned BOUNCE_STEP   = 2_500,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input logic              clk,
    input logic              rst,
    keypad_emulator_if.slave kp
);

    localparam int unsigned MsCycles = CLK_FREQ / 1000;
    localparam int unsigned CntMax   = (MsCycles > BOUNCE_CYCLES) ? MsCycles : BOUNCE_CYCLES;
    localparam int unsigned CntW     = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned StepW    = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;

    localparam logic [CntW-1:0]  BounceLast = CntW'(BOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0]  TickLast   = CntW'(MsCycles - 1);
    localparam logic [StepW-1:0] StepLast   = StepW'(BOUNCE_STEP - 1);

    typedef enum logic [1:0] {StIdle, StBounceIn, StHeld, StBounceOut} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;    // bounce cycle count, or ms tick count in HELD
    logic [StepW-1:0]  step_q, step_d;  // cycles since last LFSR advance
    logic [7:0]        ms_q, ms_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [3:0]        key_q, key_d;
    logic [7:0]        hold_q, hold_d;
    logic              done_q, done_d;

    logic       contact;
    logic       busy;
    logic [7:0] lfsr_next;
    logic [1:0] kr, kc;
    logic [3:0] row_out;

    // x^8 + x^6 + x^5 + x^4 + 1, shift left, feedback into bit 0
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        ms_d    = ms_q;
        lfsr_d  = lfsr_q;
        key_d   = key_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        contact = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (kp.press_req) begin
                    key_d   = kp.key_code;
                    hold_d  = (kp.hold_ms == 8'd0) ? 8'd1 : kp.hold_ms;
                    cnt_d   = '0;
                    step_d  = '0;
                    state_d = StBounceIn;
                end
            end
            StBounceIn, StBounceOut: begin
                contact = lfsr_q[0];
                if (step_q == StepLast) begin
                    step_d = '0;
                    lfsr_d = lfsr_next;
                end else begin
                    step_d = step_q + 1'b1;
                end
                if (cnt_q == BounceLast) begin
                    cnt_d = '0;
                    if (state_q == StBounceIn) begin
                        contact = 1'b1;
                        ms_d    = '0;
                        state_d = StHeld;
                    end else begin
                        contact = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                contact = 1'b1;
                if (cnt_q == TickLast) begin
                    cnt_d = '0;
                    if (ms_q == hold_q - 8'd1) begin
                        step_d  = '0;
                        state_d = StBounceOut;
                    end else begin
                        ms_d = ms_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            step_q  <= '0;
            ms_q    <= '0;
            lfsr_q  <= LFSR_SEED;
            key_q   <= 4'h0;
            hold_q  <= 8'd1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            ms_q    <= ms_d;
            lfsr_q  <= lfsr_d;
            key_q   <= key_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    // Key map: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D
    always_comb begin
        kr = 2'd0;
        kc = 2'd0;
        unique case (key_q)
            4'h1: begin kr = 2'd0; kc = 2'd0; end
            4'h2: begin kr = 2'd0; kc = 2'd1; end
            4'h3: begin kr = 2'd0; kc = 2'd2; end
            4'hA: begin kr = 2'd0; kc = 2'd3; end
            4'h4: begin kr = 2'd1; kc = 2'd0; end
            4'h5: begin kr = 2'd1; kc = 2'd1; end
            4'h6: begin kr = 2'd1; kc = 2'd2; end
            4'hB: begin kr = 2'd1; kc = 2'd3; end
            4'h7: begin kr = 2'd2; kc = 2'd0; end
            4'h8: begin kr = 2'd2; kc = 2'd1; end
            4'h9: begin kr = 2'd2; kc = 2'd2; end
            4'hC: begin kr = 2'd2; kc = 2'd3; end
            4'h0: begin kr = 2'd3; kc = 2'd0; end
            4'hF: begin kr = 2'd3; kc = 2'd1; end
            4'hE: begin kr = 2'd3; kc = 2'd2; end
            4'hD: begin kr = 2'd3; kc = 2'd3; end
        endcase
    end

    // Passive matrix: no registering, so the row tracks col with zero latency.
    always_comb begin
        row_out = 4'hF;
        if (contact && !kp.col[kc]) begin
            row_out[kr] = 1'b0;
        end
    end

    assign busy           = (state_q != StIdle);
    assign kp.row         = row_out;
    assign kp.busy        = busy;
    assign kp.done        = done_q;
    assign kp.req_dropped = kp.press_req & busy;
    assign kp.contact     = contact;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus pushes cycle-stamped expected
// values; a negedge monitor pops and compares them against the DUT outputs.
module tb_keypad_emulator;

    localparam int unsigned CF   = 10_000;
    localparam int unsigned BC   = 20;
    localparam int unsigned BS   = 4;
    localparam int unsigned MSC  = 10;
    localparam logic [7:0]  SEED = 8'hA5;

    typedef enum int {KRow, KBusy, KContact, KDone, KDrop, KDcount} kind_e;
    typedef struct {
        int    cyc;
        kind_e kind;
        int    val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    keypad_emulator_if kp();

    keypad_emulator #(
        .CLK_FREQ     (CF),
        .BOUNCE_CYCLES(BC),
        .BOUNCE_STEP  (BS),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    initial forever #5 clk = ~clk;

    exp_t       sb[$];
    int         cyc        = 0;
    int         n_checks   = 0;
    int         n_pass     = 0;
    int         done_seen  = 0;
    int         exp_done   = 0;
    int         last_done  = 0;
    logic [7:0] m_lfsr     = SEED;

    // Hand-written key map (index = key code)
    int kr_tab[16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
    int kc_tab[16] = '{0, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 2, 1};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic void push(input int c, input kind_e k, input int v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endfunction

    function automatic logic [3:0] exp_row(input logic [3:0] code, input logic [3:0] c);
        logic [3:0] r;
        r = 4'hF;
        if (c[kc_tab[code]] == 1'b0) r[kr_tab[code]] = 1'b0;
        return r;
    endfunction

    task automatic check(input exp_t e);
        int    act;
        string nm;
        case (e.kind)
            KRow:     begin act = int'(kp.row);         nm = "row";        end
            KBusy:    begin act = int'(kp.busy);        nm = "busy";       end
            KContact: begin act = int'(kp.contact);     nm = "contact";    end
            KDone:    begin act = int'(kp.done);        nm = "done";       end
            KDrop:    begin act = int'(kp.req_dropped); nm = "req_dropped"; end
            KDcount:  begin act = done_seen;            nm = "done_count"; end
            default:  begin act = -1;                   nm = "unknown";    end
        endcase
        n_checks++;
        if (e.cyc < cyc)
            $display("FAIL %s cycle %0d: expectation never sampled", nm, e.cyc);
        else if (act == e.val)
            n_pass++;
        else
            $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, e.cyc, act, e.val);
    endtask

    always @(negedge clk) begin
        if (kp.done === 1'b1) done_seen++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                check(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue a press in the current cycle and queue its full predicted response.
    task automatic start_press(input logic [3:0] code, input logic [7:0] hold, output int c0);
        int h;
        int c;
        h  = (hold == 8'd0) ? 1 : int'(hold);
        c0 = cyc;
        kp.key_code  = code;
        kp.hold_ms   = hold;
        kp.press_req = 1'b1;
        push(c0, KBusy, 0);
        push(c0, KDrop, 0);
        push(c0 + 1, KBusy, 1);
        c = c0 + 1;
        for (int i = 0; i < int'(BC); i++) begin
            push(c + i, KContact, (i == int'(BC) - 1) ? 1 : int'(m_lfsr[0]));
            if ((i % int'(BS)) == int'(BS) - 1) m_lfsr = lfsr_step(m_lfsr);
        end
        c += BC;
        for (int i = 0; i < h * int'(MSC); i++) push(c + i, KContact, 1);
        c += h * int'(MSC);
        for (int i = 0; i < int'(BC); i++) begin
            push(c + i, KContact, (i == int'(BC) - 1) ? 0 : int'(m_lfsr[0]));
            if ((i % int'(BS)) == int'(BS) - 1) m_lfsr = lfsr_step(m_lfsr);
        end
        c += BC;
        push(c - 1, KDone, 0);
        push(c - 1, KBusy, 1);
        push(c, KDone, 1);
        push(c, KBusy, 0);
        push(c, KContact, 0);
        exp_done++;
        last_done = c;
        @(posedge clk);
        #1;
        kp.press_req = 1'b0;
    endtask

    // Walk one low column per cycle through all four columns while HELD.
    task automatic rows_sweep(input logic [3:0] code, input int start);
        for (int j = 0; j < 4; j++) begin
            goto(start + j);
            kp.col = ~(4'b0001 << j);
            push(cyc, KRow, int'(exp_row(code, kp.col)));
        end
        goto(start + 4);
        kp.col = 4'hF;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst          = 1'b1;
        kp.col       = 4'b0000;
        kp.key_code  = 4'h0;
        kp.hold_ms   = 8'd0;
        kp.press_req = 1'b0;

        // Reset: row released even with every column strobed
        @(posedge clk);
        #1;
        push(cyc, KRow, 'hF);
        push(cyc, KBusy, 0);
        push(cyc, KContact, 0);
        push(cyc, KDone, 0);
        push(cyc, KDrop, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            goto(cyc + 1);
            push(cyc, KRow, 'hF);
            push(cyc, KBusy, 0);
            push(cyc, KContact, 0);
        end
        kp.col = 4'hF;
        goto(cyc + 1);

        // Single press of 5, hold 3 ms
        start_press(4'h5, 8'd3, c0);
        goto(c0 + 22);
        kp.col = 4'b1101;
        push(cyc, KRow, 'b1101);
        goto(c0 + 23);
        kp.col = 4'b1011;
        push(cyc, KRow, 'hF);
        goto(c0 + 24);
        kp.col = 4'b0000;
        push(cyc, KRow, 'b1101);
        goto(c0 + 25);
        kp.col = 4'hF;
        goto(last_done + 1);

        // Full key map sweep
        for (int k = 0; k < 16; k++) begin
            start_press(4'(k), 8'd1, c0);
            rows_sweep(4'(k), c0 + 21);
            goto(last_done + 1);
        end

        // Collision mid-HELD, then a request on the done cycle
        start_press(4'h9, 8'd2, c0);
        goto(c0 + 25);
        kp.key_code  = 4'h1;
        kp.hold_ms   = 8'd5;
        kp.press_req = 1'b1;
        push(cyc, KDrop, 1);
        push(cyc, KBusy, 1);
        goto(c0 + 26);
        kp.press_req = 1'b0;
        push(cyc, KDrop, 0);
        rows_sweep(4'h9, c0 + 27);
        goto(last_done);
        start_press(4'hE, 8'd1, c0);
        rows_sweep(4'hE, c0 + 21);
        goto(last_done + 1);

        // hold_ms = 0 behaves as 1 ms
        start_press(4'h3, 8'd0, c0);
        goto(last_done + 1);

        // Asynchronous reset mid-HELD
        start_press(4'h7, 8'd4, c0);
        goto(c0 + 25);
        kp.col = 4'b1110;
        push(cyc, KRow, 'b1011);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc >= cyc) sb.delete(i);
        end
        push(cyc, KRow, 'hF);
        push(cyc, KContact, 0);
        push(cyc, KBusy, 0);
        exp_done--;
        m_lfsr = SEED;
        goto(cyc + 2);
        #1;
        rst = 1'b0;
        goto(cyc + 1);
        kp.col = 4'hF;
        start_press(4'h7, 8'd4, c0);
        rows_sweep(4'h7, c0 + 21);
        goto(last_done + 2);

        push(cyc, KDcount, exp_done);
        goto(cyc + 2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
